// File: rtl/uart_send.sv
// 8N1 UART transmitter: one start bit, DATA_BITS data bits LSB-first, one stop bit.
// Every output comes straight from a flop, so TXD and IDLE cannot glitch.
module uart_send #(
  parameter int CLKS_PER_BIT = 27,
  parameter int DATA_BITS    = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] DATA,
  input  logic                 DATA_READY,
  output logic                 TXD,
  output logic                 IDLE
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   txd_q, txd_d;
  logic                   idle_q, idle_d;

  logic                   bit_end;
  logic [IDX_W-1:0]       bit_idx_nxt;

  assign bit_end     = (clk_cnt_q == CNT_MAX);
  assign bit_idx_nxt = bit_idx_q + 1'b1;

  // The start bit is launched on the accepting edge itself, so the level
  // written to txd_d is always the one for the cycle that follows the edge.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    idle_d    = idle_q;

    unique case (state_q)
      S_IDLE: begin
        txd_d     = 1'b1;
        idle_d    = 1'b1;
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (DATA_READY) begin
          shift_d = DATA;
          txd_d   = 1'b0;
          idle_d  = 1'b0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          txd_d     = shift_q[0];
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == IDX_MAX) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_nxt;
            txd_d     = shift_q[bit_idx_nxt];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          txd_d     = 1'b1;
          idle_d    = 1'b1;
          state_d   = S_IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      default: begin
        txd_d   = 1'b1;
        idle_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset abandons any partial frame: the line goes high without a stop bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      idle_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      idle_q    <= idle_d;
    end
  end

  assign TXD  = txd_q;
  assign IDLE = idle_q;

endmodule

// File: tb/tb_uart_send.sv
// Scoreboard bench for uart_send: requested bytes are queued as they are driven
// and a cycle-accurate line monitor decodes each frame and checks it against them.
`timescale 1ns/1ps
module tb_uart_send;

  localparam int CPB   = 27;
  localparam int DB    = 8;
  localparam int FRAME = (DB + 2) * CPB;

  typedef struct {
    logic [DB-1:0] data;
    bit            b2b;
  } sb_entry_t;

  logic          CLK;
  logic          RST;
  logic [DB-1:0] DATA;
  logic          DATA_READY;
  logic          TXD;
  logic          IDLE;

  int n_checks = 0;
  int n_fail   = 0;

  sb_entry_t sb[$];
  sb_entry_t cur;

  int            cyc        = 0;
  int            last_end   = -100;
  bit            mon_active = 0;
  bit            mon_post   = 0;
  int            mon_cnt    = 0;
  int            lvl_err    = 0;
  int            idle_err   = 0;
  logic [DB-1:0] rx;

  uart_send #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DATA       (DATA),
    .DATA_READY (DATA_READY),
    .TXD        (TXD),
    .IDLE       (IDLE)
  );

  initial CLK = 1'b0;
  always #18.5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Line monitor, sampled on the falling edge, half a period from any update.
  always @(negedge CLK) begin
    int slot;
    int off;
    cyc++;
    if (!RST) begin
      mon_active = 0;
      mon_post   = 0;
    end else begin
      if (mon_post) begin
        check("idle_after_frame", {31'd0, IDLE}, 32'd1);
        check("txd_after_frame", {31'd0, TXD}, 32'd1);
        mon_post = 0;
      end else if (!mon_active && TXD === 1'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          cur = '{data: '0, b2b: 1'b0};
        end else begin
          cur = sb.pop_front();
          if (cur.b2b) check("idle_gap", cyc - last_end - 1, 32'd1);
        end
        mon_active = 1;
        mon_cnt    = 0;
        lvl_err    = 0;
        idle_err   = 0;
        rx         = '0;
      end

      if (mon_active) begin
        slot = mon_cnt / CPB;
        off  = mon_cnt % CPB;
        if (IDLE !== 1'b0) idle_err++;
        if (slot == 0) begin
          if (TXD !== 1'b0) lvl_err++;
        end else if (slot == DB + 1) begin
          if (TXD !== 1'b1) lvl_err++;
        end else if (off == 0) begin
          rx[slot-1] = TXD;
        end else if (TXD !== rx[slot-1]) begin
          lvl_err++;
        end
        mon_cnt++;
        if (mon_cnt == FRAME) begin
          check("frame_levels", lvl_err, 32'd0);
          check("idle_low_270", idle_err, 32'd0);
          check("rx_byte", {24'd0, rx}, {24'd0, cur.data});
          mon_active = 0;
          mon_post   = 1;
          last_end   = cyc;
        end
      end
    end
  end

  // Queues n_frames copies of d, the later ones expected back-to-back.
  task automatic send(input logic [DB-1:0] d, input int n_frames, input bit first_b2b,
                      input int hold);
    @(negedge CLK);
    DATA       = d;
    DATA_READY = 1'b1;
    for (int i = 0; i < n_frames; i++) sb.push_back('{data: d, b2b: (i == 0) ? first_b2b : 1'b1});
    repeat (hold) @(negedge CLK);
    DATA_READY = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while ((mon_active || mon_post || sb.size() != 0) && n < bound) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (n >= bound) check("wait_done_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    RST        = 1'b0;
    DATA       = 'x;
    DATA_READY = 1'b0;

    repeat (4) begin
      @(negedge CLK);
      check("reset_txd", {31'd0, TXD}, 32'd1);
      check("reset_idle", {31'd0, IDLE}, 32'd1);
    end
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("post_reset_txd", {31'd0, TXD}, 32'd1);
    check("post_reset_idle", {31'd0, IDLE}, 32'd1);

    // 0xAA held for 27 clocks, then 0x4C requested 270 clocks after it.
    send(8'hAA, 1, 1'b0, 27);
    DATA = 'x;
    repeat (242) @(negedge CLK);
    check("busy_before_4c", {31'd0, IDLE}, 32'd0);
    send(8'h4C, 1, 1'b1, 27);
    DATA = 'x;
    wait_done(1000);
    repeat (5) @(negedge CLK);

    // DATA changes to 0xFF during data bit 3; 0x55 must still go out.
    send(8'h55, 1, 1'b0, 1);
    repeat (110) @(negedge CLK);
    DATA = 8'hFF;
    wait_done(1000);
    DATA = 'x;
    repeat (5) @(negedge CLK);

    // Continuous request: three frames, each one idle cycle apart.
    send(8'h01, 3, 1'b0, 803);
    DATA = 'x;
    wait_done(1000);
    repeat (5) @(negedge CLK);

    // Reset asserted during data bit 4 of 0xC3 (bit 4 is 0 on the line).
    send(8'hC3, 1, 1'b0, 1);
    DATA = 'x;
    repeat (144) @(negedge CLK);
    check("bit4_low_before_rst", {31'd0, TXD}, 32'd0);
    @(posedge CLK);
    #5 RST = 1'b0;
    #1;
    check("async_rst_txd", {31'd0, TXD}, 32'd1);
    check("async_rst_idle", {31'd0, IDLE}, 32'd1);
    repeat (2) @(negedge CLK);
    check("rst_hold_txd", {31'd0, TXD}, 32'd1);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("abort_flushed", sb.size(), 32'd0);

    send(8'h96, 1, 1'b0, 1);
    DATA = 'x;
    wait_done(1000);
    repeat (5) @(negedge CLK);

    check("scoreboard_empty", sb.size(), 32'd0);
    check("final_idle", {31'd0, IDLE}, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(37 * 50000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_send.md
Name: uart_send

Overview:
- 8N1 UART transmitter. Serialises one byte per request onto TXD: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1).
- Sits between a byte producer (debug/telemetry path in the camera design) and the board's serial TX pin.
- Runs on the 27 MHz system clock. The default is 1 Mbaud, i.e. 27 clocks per bit.
- IDLE tells the producer when a new byte can be accepted.

Parameters:
- CLKS_PER_BIT, 27, clock cycles per serial bit (27 MHz / 1 Mbaud); legal range ≥ 2.
- DATA_BITS, 8, data bits per frame.

Ports:
- CLK  input  1  system clock (27 MHz nominal); all logic on rising edge.
- RST  input  1  reset, asynchronous, active-low (0 = reset asserted).
- DATA  input  DATA_BITS  byte to send; sampled only at frame acceptance.
- DATA_READY  input  1  level request: a byte is valid on DATA.
- TXD  output  1  serial line; idles high.
- IDLE  output  1  1 = no frame in progress and a request can be accepted.

Behaviour:
- Reset (RST=0, asynchronous):
  - TXD=1, IDLE=1; state=S_IDLE; bit counter, clock counter and shift register cleared.
  - Reset takes effect mid-frame too: the line returns high immediately and the partial frame is abandoned, with no stop-bit completion.
- All outputs are registered and glitch-free.
- States:
  - S_IDLE, S_START, S_DATA, S_STOP.
- S_IDLE:
  - TXD=1, IDLE=1.
  - On a rising edge with DATA_READY=1:
    - latch DATA into the shift register;
    - TXD←0, IDLE←0;
    - clock counter←0; go to S_START.
  - Latency from the sampling edge to the start bit on TXD is 0 cycles, i.e. the start bit appears on that same edge.
- S_START:
  - TXD=0 for exactly CLKS_PER_BIT cycles, then go to S_DATA with bit index 0.
- S_DATA:
  - TXD = shift register bit[index], LSB first.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - After bit DATA_BITS-1, go to S_STOP.
- S_STOP:
  - TXD=1 for CLKS_PER_BIT cycles.
  - Then go to S_IDLE and set IDLE←1 on that edge.
- Frame length:
  - (DATA_BITS+2)·CLKS_PER_BIT cycles = 270 cycles = 10.0 µs at defaults.
  - IDLE is low for exactly 270 cycles.
- Handshake:
  - DATA_READY is level-sensitive and is only looked at in S_IDLE.
  - DATA and DATA_READY are ignored while IDLE=0; DATA may change or go X after acceptance.
  - If DATA_READY is still 1 when IDLE returns to 1, a new frame starts on the next edge. Producers must deassert before the frame ends (≤ 270 cycles) to send one byte.
  - Minimum gap between back-to-back frames is 1 idle cycle with TXD=1.
- Counters:
  - The clock counter is wide enough for CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - The bit index is wide enough for DATA_BITS-1.
- No parity, no break generation, no FIFO.

Test Plan:
- Reset: hold RST=0 for 4 clocks with DATA=X → TXD=1, IDLE=1 throughout. Release RST=1 → still TXD=1, IDLE=1 with DATA_READY=0.
- Byte 0xAA:
  - Stimulus: DATA=0xAA, DATA_READY=1 for 1000 ns (27 clocks), then DATA=X.
  - TXD, each level for 27 clocks: 0 (start), then 0,1,0,1,0,1,0,1, then 1 (stop).
  - IDLE low for 270 clocks, then high.
  - Exactly one frame is sent.
- Byte 0x4C sent 10 µs after the first request:
  - TXD: 0, then 0,0,1,1,0,0,1,0, then 1.
  - The request is held across the tail of the previous frame and is accepted on the first edge after IDLE=1.
- DATA changed mid-frame (0x55 → 0xFF at bit 3) → transmitted bits remain those of 0x55.
- DATA_READY held high continuously with DATA=0x01 → consecutive frames separated by exactly 1 idle cycle, each 0, 1,0,0,0,0,0,0,0, 1.
- RST pulsed low during data bit 4 → TXD=1 and IDLE=1 immediately, without waiting for a clock edge. Next request produces a complete, correct frame.
